// File: rtl/pipe_tracker_pkg.sv
// Shared CPU pipeline constants: instruction width, bubble word, stage indices.
// No logic; constants only.
// Imported by the tracker and its stage register.
package pipe_tracker_pkg;
  localparam int IW = 16;
  localparam logic [15:0] BUBBLE = 16'h0000;

  localparam int IF_ID      = 0;
  localparam int ID_EX      = 1;
  localparam int EX_M       = 2;
  localparam int M_WB       = 3;
  localparam int NUM_STAGES = 4;
endpackage

// File: rtl/pipe_stage_reg.sv
// One {instruction, valid} pipeline register with flush/hold/bubble/advance control.
// Latency: one cycle from in_* to outputs when advancing.
// Backpressure: hold keeps contents; flush wins over hold; bubble inserts an empty slot.
module pipe_stage_reg
  import pipe_tracker_pkg::*;
#(
  parameter int          IW     = pipe_tracker_pkg::IW,
  parameter logic [IW-1:0] BUBBLE = pipe_tracker_pkg::BUBBLE[IW-1:0]
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic          bubble,
  input  logic [IW-1:0] in_instruction,
  input  logic          in_valid,
  output logic [IW-1:0] instruction,
  output logic          valid
);

  // Priority per edge: reset, flush, hold, bubble, advance.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      instruction <= BUBBLE;
      valid       <= 1'b0;
    end else if (hold) begin
      instruction <= instruction;
      valid       <= valid;
    end else if (bubble) begin
      instruction <= BUBBLE;
      valid       <= 1'b0;
    end else begin
      instruction <= in_instruction;
      valid       <= in_valid;
    end
  end

endmodule

// File: rtl/pipe_tracker.sv
// Four-stage in-order pipeline tracker (IF/ID, ID/EX, EX/M, M/WB) with retire/stall counters.
// Latency: one cycle per unheld stage; fetch to WB in 4 edges.
// Backpressure: a lock holds its stage and everything upstream; fetch_stall tells the PC to wait.
module pipe_tracker
  import pipe_tracker_pkg::*;
#(
  parameter int            IW     = pipe_tracker_pkg::IW,
  parameter logic [IW-1:0] BUBBLE = pipe_tracker_pkg::BUBBLE[IW-1:0]
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] if_instruction,
  input  logic          if_valid,
  input  logic          if_id_lock,
  input  logic          id_ex_lock,
  input  logic          ex_m_lock,
  input  logic          m_wb_lock,
  input  logic          if_id_flush,
  input  logic          id_ex_flush,
  input  logic          ex_m_flush,
  input  logic          m_wb_flush,
  output logic [IW-1:0] id_instruction,
  output logic [IW-1:0] ex_instruction,
  output logic [IW-1:0] m_instruction,
  output logic [IW-1:0] wb_instruction,
  output logic          id_valid,
  output logic          ex_valid,
  output logic          m_valid,
  output logic          wb_valid,
  output logic          fetch_stall,
  output logic          retire,
  output logic [15:0]   retire_count,
  output logic [15:0]   stall_count
);

  logic                  hold_wb, hold_m, hold_ex, hold_id;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] flush;
  logic [NUM_STAGES-1:0] bubble;
  logic [IW-1:0]         src_instruction [NUM_STAGES];
  logic                  src_valid       [NUM_STAGES];
  logic [IW-1:0]         stage_instruction [NUM_STAGES];
  logic                  stage_valid       [NUM_STAGES];

  // Holds ripple upstream; a flush does not break the chain.
  assign hold_wb = m_wb_lock;
  assign hold_m  = ex_m_lock  | hold_wb;
  assign hold_ex = id_ex_lock | hold_m;
  assign hold_id = if_id_lock | hold_ex;
  assign hold    = {hold_wb, hold_m, hold_ex, hold_id};
  assign flush   = {m_wb_flush, ex_m_flush, id_ex_flush, if_id_flush};

  // A stage gets a bubble when its upstream neighbour is held; IF/ID has no upstream register.
  assign bubble = {hold[EX_M], hold[ID_EX], hold[IF_ID], 1'b0};

  // Each stage's advance source: the fetch port for IF/ID, otherwise the previous register.
  always_comb begin
    src_instruction[IF_ID] = if_valid ? if_instruction : BUBBLE;
    src_valid[IF_ID]       = if_valid;
    for (int i = 1; i < NUM_STAGES; i++) begin
      src_instruction[i] = stage_instruction[i-1];
      src_valid[i]       = stage_valid[i-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_stage_reg #(.IW(IW), .BUBBLE(BUBBLE)) u_reg (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush[g]),
      .hold           (hold[g]),
      .bubble         (bubble[g]),
      .in_instruction (src_instruction[g]),
      .in_valid       (src_valid[g]),
      .instruction    (stage_instruction[g]),
      .valid          (stage_valid[g])
    );
  end

  assign id_instruction = stage_instruction[IF_ID];
  assign ex_instruction = stage_instruction[ID_EX];
  assign m_instruction  = stage_instruction[EX_M];
  assign wb_instruction = stage_instruction[M_WB];
  assign id_valid       = stage_valid[IF_ID];
  assign ex_valid       = stage_valid[ID_EX];
  assign m_valid        = stage_valid[EX_M];
  assign wb_valid       = stage_valid[M_WB];

  // A flush of IF/ID overrides its hold, so the PC may move on.
  assign fetch_stall = hold_id & ~if_id_flush;

  // Retire pulse and wrapping retire counter, both registered on the edge WB drains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      retire       <= 1'b0;
      retire_count <= 16'h0000;
    end else begin
      retire <= stage_valid[M_WB] & ~m_wb_lock & ~m_wb_flush;
      if (stage_valid[M_WB] && !m_wb_lock && !m_wb_flush) begin
        retire_count <= retire_count + 16'd1;
      end
    end
  end

  // Saturating count of cycles the fetch stage was stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= 16'h0000;
    end else if (fetch_stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_tracker.sv
// Self-checking bench for pipe_tracker: directed scenarios plus randomized hazards.
// Reference keeps stage contents in plain arrays and applies the stage rules each edge.
// Outputs are compared one time unit after inputs settle, away from the rising edge.
module tb_pipe_tracker;

  logic        clk;
  logic        reset;
  logic [15:0] if_instruction;
  logic        if_valid;
  logic [3:0]  lk;
  logic [3:0]  fl;
  logic [15:0] id_instruction, ex_instruction, m_instruction, wb_instruction;
  logic        id_valid, ex_valid, m_valid, wb_valid;
  logic        fetch_stall, retire;
  logic [15:0] retire_count, stall_count;

  pipe_tracker dut (
    .clk            (clk),
    .reset          (reset),
    .if_instruction (if_instruction),
    .if_valid       (if_valid),
    .if_id_lock     (lk[0]),
    .id_ex_lock     (lk[1]),
    .ex_m_lock      (lk[2]),
    .m_wb_lock      (lk[3]),
    .if_id_flush    (fl[0]),
    .id_ex_flush    (fl[1]),
    .ex_m_flush     (fl[2]),
    .m_wb_flush     (fl[3]),
    .id_instruction (id_instruction),
    .ex_instruction (ex_instruction),
    .m_instruction  (m_instruction),
    .wb_instruction (wb_instruction),
    .id_valid       (id_valid),
    .ex_valid       (ex_valid),
    .m_valid        (m_valid),
    .wb_valid       (wb_valid),
    .fetch_stall    (fetch_stall),
    .retire         (retire),
    .retire_count   (retire_count),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit model_ok = 1'b0;

  // Reference state
  logic [15:0] mi [4];
  logic        mv [4];
  logic        mr;
  int          ms;
  int          mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A stage is held if its own lock or any downstream lock is set.
  function automatic bit mhold(input int n);
    for (int k = n; k < 4; k++) if (lk[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    logic [15:0] oi [4];
    logic        ov [4];
    logic [15:0] si;
    logic        sv;
    for (int n = 0; n < 4; n++) begin oi[n] = mi[n]; ov[n] = mv[n]; end
    if (!reset) begin
      for (int n = 0; n < 4; n++) begin mi[n] = 16'h0000; mv[n] = 1'b0; end
      mr = 1'b0; ms = 0; mc = 0;
    end else begin
      mr = ov[3] && !lk[3] && !fl[3];
      if (mr) mc = (mc + 1) % 65536;
      if (mhold(0) && !fl[0] && ms < 65535) ms = ms + 1;
      for (int n = 0; n < 4; n++) begin
        if (n == 0) begin
          si = if_valid ? if_instruction : 16'h0000;
          sv = if_valid;
        end else begin
          si = oi[n-1];
          sv = ov[n-1];
        end
        if (fl[n]) begin
          mi[n] = 16'h0000; mv[n] = 1'b0;
        end else if (mhold(n)) begin
          mi[n] = oi[n]; mv[n] = ov[n];
        end else if (n > 0 && mhold(n-1)) begin
          mi[n] = 16'h0000; mv[n] = 1'b0;
        end else begin
          mi[n] = si; mv[n] = sv;
        end
      end
    end
  endtask

  task automatic compare_all();
    if (model_ok) begin
      chk("id_instruction", id_instruction, mi[0]);
      chk("ex_instruction", ex_instruction, mi[1]);
      chk("m_instruction",  m_instruction,  mi[2]);
      chk("wb_instruction", wb_instruction, mi[3]);
      chk("id_valid", id_valid, mv[0]);
      chk("ex_valid", ex_valid, mv[1]);
      chk("m_valid",  m_valid,  mv[2]);
      chk("wb_valid", wb_valid, mv[3]);
      chk("fetch_stall", fetch_stall, mhold(0) && !fl[0]);
      chk("retire", retire, mr);
      chk("retire_count", retire_count, mc[15:0]);
      chk("stall_count",  stall_count,  ms[15:0]);
    end
  endtask

  // Compare, take one rising edge, advance the reference, return at the falling edge.
  task automatic cycle();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b1; lk = 4'h0; fl = 4'h0; if_valid = 1'b0; if_instruction = 16'h0000;
  endtask

  task automatic feed(input logic [15:0] w);
    if_instruction = w; if_valid = 1'b1;
    cycle();
    if_valid = 1'b0; if_instruction = 16'h0000;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    cycle();
    model_ok = 1'b1;
    reset = 1'b1;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset state
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_retire_count", retire_count, 16'h0000);

    // No-hazard flow: F050, C000, F051
    if_instruction = 16'hF050; if_valid = 1'b1; cycle();
    if_instruction = 16'hC000; cycle();
    if_instruction = 16'hF051; cycle();
    if_valid = 1'b0; if_instruction = 16'h0000; cycle();
    chk("flow_edge4", wb_instruction, 16'hF050);
    cycle();
    chk("flow_edge5", wb_instruction, 16'hC000);
    cycle();
    chk("flow_edge6", wb_instruction, 16'hF051);
    cycle(); cycle();
    chk("flow_retire_count", retire_count, 16'd3);

    // ex_m_lock for one cycle with C000 in M and F050 in EX
    do_reset();
    feed(16'hC000); feed(16'hF050); feed(16'hF051);
    chk("lock_pre_m", m_instruction, 16'hC000);
    chk("lock_pre_ex", ex_instruction, 16'hF050);
    lk[2] = 1'b1;
    #1 chk("lock_fetch_stall", fetch_stall, 1'b1);
    cycle();
    lk[2] = 1'b0;
    chk("lock_m_held", m_instruction, 16'hC000);
    chk("lock_ex_held", ex_instruction, 16'hF050);
    chk("lock_wb_bubble", wb_valid, 1'b0);
    chk("lock_stall_count", stall_count, 16'd1);

    // Jump taken: flush IF/ID and ID/EX
    do_reset();
    feed(16'hA001); feed(16'hA002); feed(16'hA003);
    fl[0] = 1'b1; fl[1] = 1'b1; if_instruction = 16'hA004; if_valid = 1'b1;
    #1 chk("jump_fetch_stall", fetch_stall, 1'b0);
    cycle();
    idle();
    chk("jump_id_valid", id_valid, 1'b0);
    chk("jump_ex_valid", ex_valid, 1'b0);
    chk("jump_m_adv", m_instruction, 16'hA002);

    // Lock and flush of IF/ID together: flush wins
    feed(16'hB001);
    lk[0] = 1'b1; fl[0] = 1'b1;
    #1 chk("lf_fetch_stall", fetch_stall, 1'b0);
    cycle();
    idle();
    chk("lf_id_valid", id_valid, 1'b0);

    // Reset with a full pipe while m_wb_lock is set
    feed(16'h1111); feed(16'h2222); feed(16'h3333); feed(16'h4444);
    chk("full_wb_valid", wb_valid, 1'b1);
    lk[3] = 1'b1; reset = 1'b0;
    cycle();
    chk("rfull_valid", {id_valid, ex_valid, m_valid, wb_valid}, 4'h0);
    chk("rfull_wb_instr", wb_instruction, 16'h0000);
    chk("rfull_id_instr", id_instruction, 16'h0000);
    chk("rfull_counts", {retire_count, stall_count}, 32'h0);
    idle();
    feed(16'h5555);
    chk("post_reset_capture", id_instruction, 16'h5555);

    // Stall counter saturation
    do_reset();
    lk[0] = 1'b1;
    for (int i = 0; i < 65540; i++) cycle();
    chk("stall_saturate", stall_count, 16'hFFFF);
    idle();

    // Randomized hazards
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if_valid       = ($urandom_range(0, 3) != 0);
      if_instruction = 16'($urandom);
      for (int k = 0; k < 4; k++) begin
        lk[k] = ($urandom_range(0, 7) == 0);
        fl[k] = ($urandom_range(0, 9) == 0);
      end
      reset = ($urandom_range(0, 149) != 0);
      cycle();
    end
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
